// File: rtl/fft_result_reader.sv
// Purpose: read side of the 64-point FFT working RAM. Sweeps bins two per
//   fetch, converts each complex bin to |re|+|im| and streams (bin, magnitude)
//   over valid/ready while tracking the peak bin. Never writes the RAM.
// Latency: 3 cycles per bin pair with out_ready high (FETCH, EMIT_A, EMIT_B).
// Backpressure: out_ready low holds the current word in EMIT_A/EMIT_B
//   indefinitely. The RAM is not re-read because the data is already registered.
// Ports:
//   clk, reset (async, active-high), start (one-cycle pulse, IDLE only)
//   address_a/address_b -> RAM read addresses; q_a/q_b <- {re[31:16], im[15:0]}
//   out_valid/out_ready/out_bin/out_mag : result stream
//   peak_bin/peak_mag : largest magnitude seen this sweep; busy, done status
module fft_result_reader #(
  parameter int NUM_BINS    = 32,
  parameter bit BIT_REVERSE = 1'b0,
  parameter bit SKIP_DC     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [5:0]  address_a,
  output logic [5:0]  address_b,
  input  logic [31:0] q_a,
  input  logic [31:0] q_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_bin,
  output logic [16:0] out_mag,
  output logic [5:0]  peak_bin,
  output logic [16:0] peak_mag,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FETCH, EMIT_A, EMIT_B, DONE} state_t;

  localparam logic [4:0] K_LAST = 5'(NUM_BINS / 2 - 1);

  state_t      state, state_nxt;
  logic [4:0]  k;
  logic [16:0] mag_a, mag_b;
  logic [5:0]  bin_a, bin_b;
  logic        accept;
  logic        peak_hit;

  function automatic logic [5:0] bitrev6(input logic [5:0] x);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = x[5-i];
    return r;
  endfunction

  // Sign-extend to 17 bits first so that |-32768| = 32768 is representable.
  function automatic logic [16:0] abs17(input logic [15:0] x);
    logic [16:0] sx;
    sx = {x[15], x};
    return x[15] ? (~sx + 17'd1) : sx;
  endfunction

  function automatic logic [16:0] l1mag(input logic [31:0] q);
    return abs17(q[31:16]) + abs17(q[15:0]);
  endfunction

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_bin   = 6'd0;
    out_mag   = 17'd0;
    busy      = (state != IDLE);
    done      = 1'b0;
    bin_a     = 6'd0;
    bin_b     = 6'd0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        bin_a     = {k, 1'b0};
        bin_b     = {k, 1'b1};
        state_nxt = EMIT_A;
      end
      EMIT_A: begin
        out_valid = 1'b1;
        out_bin   = {k, 1'b0};
        out_mag   = mag_a;
        if (out_ready) state_nxt = EMIT_B;
      end
      EMIT_B: begin
        out_valid = 1'b1;
        out_bin   = {k, 1'b1};
        out_mag   = mag_b;
        if (out_ready) state_nxt = (k == K_LAST) ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign address_a = BIT_REVERSE ? bitrev6(bin_a) : bin_a;
  assign address_b = BIT_REVERSE ? bitrev6(bin_b) : bin_b;

  assign accept   = out_valid && out_ready;
  // Strict greater-than keeps the lowest index on ties (bins arrive in order).
  assign peak_hit = accept && (out_mag > peak_mag) &&
                    !(SKIP_DC && (out_bin == 6'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      k        <= 5'd0;
      mag_a    <= 17'd0;
      mag_b    <= 17'd0;
      peak_bin <= 6'd0;
      peak_mag <= 17'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        k        <= 5'd0;
        peak_bin <= 6'd0;
        peak_mag <= 17'd0;
      end
      if (state == FETCH) begin
        mag_a <= l1mag(q_a);
        mag_b <= l1mag(q_b);
      end
      if (state == EMIT_B && out_ready && k != K_LAST) k <= k + 5'd1;
      if (peak_hit) begin
        peak_bin <= out_bin;
        peak_mag <= out_mag;
      end
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Scoreboard bench for fft_result_reader: two instances share stimulus.
// dut_a: defaults (linear addressing, DC skipped in peak search).
// dut_b: bit-reversed addressing, DC included. Each has its own RAM image.
module tb_fft_result_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  bit   bp_mode = 1'b0;
  bit   ready_hold = 1'b1;
  int   cyc_r = 0;

  logic [31:0] ram_a [64];
  logic [31:0] ram_b [64];

  logic [5:0]  a_addr_a, a_addr_b, b_addr_a, b_addr_b;
  logic [31:0] a_qa, a_qb, b_qa, b_qb;
  logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [5:0]  a_bin, b_bin, a_pbin, b_pbin;
  logic [16:0] a_mag, b_mag, a_pmag, b_pmag;

  assign a_qa = ram_a[a_addr_a];
  assign a_qb = ram_a[a_addr_b];
  assign b_qa = ram_b[b_addr_a];
  assign b_qb = ram_b[b_addr_b];

  fft_result_reader #(.NUM_BINS(32), .BIT_REVERSE(1'b0), .SKIP_DC(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .address_a(a_addr_a), .address_b(a_addr_b), .q_a(a_qa), .q_b(a_qb),
    .out_valid(a_valid), .out_ready(out_ready), .out_bin(a_bin), .out_mag(a_mag),
    .peak_bin(a_pbin), .peak_mag(a_pmag), .busy(a_busy), .done(a_done));

  fft_result_reader #(.NUM_BINS(32), .BIT_REVERSE(1'b1), .SKIP_DC(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .address_a(b_addr_a), .address_b(b_addr_b), .q_a(b_qa), .q_b(b_qb),
    .out_valid(b_valid), .out_ready(out_ready), .out_bin(b_bin), .out_mag(b_mag),
    .peak_bin(b_pbin), .peak_mag(b_pmag), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  // Ready driver: 1-of-3 pattern in backpressure mode, else a held level.
  always @(posedge clk) begin
    #1;
    cyc_r++;
    out_ready = bp_mode ? (cyc_r % 3 == 0) : ready_hold;
  end

  int n_chk = 0;
  int n_fail = 0;
  int done_count = 0;
  logic [22:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected word on every accept, checks hold-while-stalled.
  bit          prev_hold = 1'b0;
  logic [5:0]  prev_bin;
  logic [16:0] prev_mag;
  always @(negedge clk) begin
    logic [22:0] e;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_valid", 32'(a_valid), 32'd1);
        chk("stall_bin", 32'(a_bin), 32'(prev_bin));
        chk("stall_mag", 32'(a_mag), 32'(prev_mag));
      end
      if (a_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(a_bin), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("a_bin", 32'(a_bin), 32'(e[22:17]));
          chk("a_mag", 32'(a_mag), 32'(e[16:0]));
          chk("b_valid", 32'(b_valid), 32'd1);
          chk("b_bin", 32'(b_bin), 32'(e[22:17]));
          chk("b_mag", 32'(b_mag), 32'(e[16:0]));
        end
      end
      prev_hold = a_valid && !out_ready;
      prev_bin  = a_bin;
      prev_mag  = a_mag;
    end
    if (a_done) done_count++;
  end

  function automatic logic [5:0] brev(input logic [5:0] x);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = x[5-i];
    return r;
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < 64; i++) begin
      ram_a[i] = 32'd0;
      ram_b[i] = 32'd0;
    end
  endtask

  task automatic set_bin(input int bin, input int re, input int im);
    logic [31:0] w;
    w = {re[15:0], im[15:0]};
    ram_a[bin] = w;
    ram_b[brev(6'(bin))] = w;
  endtask

  task automatic push_exp(input int bin, input int mag);
    exp_q.push_back({6'(bin), 17'(mag)});
  endtask

  // Bins {n, -n}: magnitude 2n.
  task automatic load_ramp();
    clear_ram();
    for (int n = 0; n < 32; n++) begin
      set_bin(n, n, -n);
      push_exp(n, 2 * n);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_valid"}, 32'(a_valid), 0);
    chk({tag, "_a_done"},  32'(a_done), 0);
    chk({tag, "_a_busy"},  32'(a_busy), 0);
    chk({tag, "_a_pbin"},  32'(a_pbin), 0);
    chk({tag, "_a_pmag"},  32'(a_pmag), 0);
    chk({tag, "_a_bin"},   32'(a_bin), 0);
    chk({tag, "_a_mag"},   32'(a_mag), 0);
    chk({tag, "_a_addr"},  32'({a_addr_a, a_addr_b}), 0);
    chk({tag, "_b_valid"}, 32'(b_valid), 0);
    chk({tag, "_b_busy"},  32'(b_busy), 0);
    chk({tag, "_b_peak"},  32'({b_pbin, b_pmag}), 0);
    chk({tag, "_b_addr"},  32'({b_addr_a, b_addr_b}), 0);
  endtask

  // Runs one sweep. cycles counts the start cycle through the done cycle.
  // glitch_at re-pulses start in that cycle (0 = never).
  task automatic run_sweep(input string tag, input int exp_cycles, input int glitch_at,
                           input int pa_bin, input int pa_mag,
                           input int pb_bin, input int pb_mag);
    int cycles;
    int d0;
    bit seen;
    d0 = done_count;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk); cycles = 1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); cycles++;
    chk({tag, "_fetch_busy"}, 32'(a_busy), 1);
    chk({tag, "_fetch_a_addr"}, 32'({a_addr_a, a_addr_b}), 32'({6'd0, 6'd1}));
    chk({tag, "_fetch_b_addr_b"}, 32'(b_addr_b), 32);
    seen = 1'b0;
    while (!seen && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      start = (cycles == glitch_at);
      if (a_done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    if (seen && exp_cycles > 0) chk({tag, "_cycles"}, cycles, exp_cycles);
    if (seen) begin
      chk({tag, "_done_busy"}, 32'(a_busy), 1);
      chk({tag, "_b_done"}, 32'(b_done), 1);
    end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(a_busy), 0);
    chk({tag, "_done_pulses"}, done_count - d0, 1);
    chk({tag, "_missing_words"}, exp_q.size(), 0);
    chk({tag, "_a_peak_bin"}, 32'(a_pbin), pa_bin);
    chk({tag, "_a_peak_mag"}, 32'(a_pmag), pa_mag);
    chk({tag, "_b_peak_bin"}, 32'(b_pbin), pb_bin);
    chk({tag, "_b_peak_mag"}, 32'(b_pmag), pb_mag);
    exp_q = {};
  endtask

  initial begin
    int d0;
    int guard;
    clear_ram();
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Ramp; a start coincident with the DONE cycle (cycle 50) must be ignored.
    load_ramp();
    run_sweep("ramp", 50, 50, 31, 62, 31, 62);

    // Full-scale negative bin: 32768 + 32768.
    clear_ram();
    set_bin(5, -32768, -32768);
    for (int n = 0; n < 32; n++) push_exp(n, (n == 5) ? 65536 : 0);
    run_sweep("fullscale", 50, 0, 5, 65536, 5, 65536);

    // Tie between bins 3 and 9 at 100; DC at 500 only counts when not skipped.
    clear_ram();
    set_bin(0, 250, -250);
    set_bin(3, 60, -40);
    set_bin(9, -100, 0);
    for (int n = 0; n < 32; n++)
      push_exp(n, (n == 0) ? 500 : ((n == 3 || n == 9) ? 100 : 0));
    run_sweep("tie", 50, 0, 3, 100, 0, 500);

    // Bin 1 placed explicitly: linear address 1, bit-reversed address 32.
    clear_ram();
    ram_a[1]  = {16'd7, 16'd0};
    ram_b[32] = {16'd7, 16'd0};
    for (int n = 0; n < 32; n++) push_exp(n, (n == 1) ? 7 : 0);
    run_sweep("bitrev", 50, 0, 1, 7, 1, 7);

    // Backpressure 1-of-3 with a stray start mid-sweep.
    load_ramp();
    bp_mode = 1'b1;
    run_sweep("bp", 0, 20, 31, 62, 31, 62);
    bp_mode = 1'b0;

    // Reset while EMIT_B of pair 7 (bin 15) is stalled.
    load_ramp();
    ready_hold = 1'b1;
    d0 = done_count;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    while (!(a_valid && a_bin == 6'd14) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    ready_hold = 1'b0;
    guard = 0;
    while (!(a_valid && a_bin == 6'd15) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reached_b15", 32'(a_bin), 15);
    #1 reset = 1'b1;
    #1 chk_all_zero("midrst");
    exp_q = {};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ready_hold = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_count - d0, 0);
    chk("midrst_idle", 32'(a_busy), 0);
    load_ramp();
    run_sweep("after_rst", 50, 0, 31, 62, 31, 62);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_result_reader.md
Name: fft_result_reader

Overview:
- Read side of the 64-point FFT working RAM. After the FFT core finishes, it sweeps the dual-port RAM read addresses, two bins per fetch.
- Converts each complex bin to an L1 magnitude, streams (bin, magnitude) over a valid/ready interface, and tracks the peak bin for the harmonizer pitch logic.
- Sits between the FFT RAM read ports and the pitch-detect / display logic. Never asserts the RAM write.

Parameters:
NUM_BINS, 32, number of bins read (even, 2..64); bins 0..NUM_BINS-1
BIT_REVERSE, 0, 1 = RAM holds bins in bit-reversed order; address = bitrev6(bin)
SKIP_DC, 1, 1 = bin 0 excluded from peak search (still streamed)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: begin a sweep (ignored unless IDLE)
address_a  output  6  RAM port A read address
address_b  output  6  RAM port B read address
q_a  input  32  RAM port A data, combinational read; [31:16] real, [15:0] imag, both signed two's complement
q_b  input  32  RAM port B data, same format
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_bin  output  6  bin index of current stream word
out_mag  output  17  |re|+|im| of current bin, unsigned
peak_bin  output  6  index of largest magnitude, valid when done
peak_mag  output  17  largest magnitude
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async, immediate): state IDLE, pair counter k=0. All outputs 0: out_valid, done, busy, peak_bin, peak_mag, out_bin, out_mag, address_a, address_b.
- Address mapping: bin 2k on port A, bin 2k+1 on port B. With BIT_REVERSE=1, each 6-bit index is bit-reversed before driving the port. In IDLE and DONE both addresses are 0.
- Magnitude: |x| computed in 17 bits so that |-32768| = 32768. out_mag = |re| + |im|, range 0..65536, no saturation.
- States:
  - IDLE: start=1 -> FETCH. Clear k, peak_mag and peak_bin.
  - FETCH (1 cycle): drive addresses for pair k. RAM read is combinational, so q_a/q_b are registered this same cycle into mag_a/mag_b. -> EMIT_A.
  - EMIT_A: out_valid=1, out_bin=2k, out_mag=mag_a. Outputs held stable until accepted. On accept -> EMIT_B.
  - EMIT_B: out_valid=1, out_bin=2k+1, out_mag=mag_b. On accept: if k==NUM_BINS/2-1 -> DONE, else k++ and -> FETCH.
  - DONE (1 cycle): done=1, busy=0 is not allowed (busy=1). -> IDLE.
- Peak update happens on each accepted word with mag > peak_mag (strict greater), skipping bin 0 when SKIP_DC=1.
  - Ties: lowest index wins.
  - All-zero input: peak_bin=0, peak_mag=0.
  - peak_bin/peak_mag hold their value after done until the next start.
- Throughput: 3 cycles per pair minimum, with out_ready held high.
  - NUM_BINS=32: start to done = 1 + 16*3 + 1 cycles. done is asserted in the cycle after the final accept.
- Backpressure: out_ready low stalls indefinitely in EMIT_A/EMIT_B. No RAM re-read is needed because data is already registered. out_valid never drops without an accept.
- start while busy: ignored.
- start coincident with the DONE cycle: ignored. Upstream must re-pulse.
- reset mid-sweep: returns to IDLE immediately. No done pulse; the peak is cleared.
- The RAM write is not driven by this block. The top level must hold write=0 while busy=1.

Test Plan:
- RAM bins = {re=n, im=-n} for n=0..31, BIT_REVERSE=0, out_ready=1 -> 32 words with out_mag=2n in order; peak_bin=31, peak_mag=62; done exactly 50 cycles after start.
- Bin 5 = {-32768,-32768}, all others 0 -> out_mag[5]=65536, peak_bin=5, peak_mag=65536.
- Bins 3 and 9 both mag 100, bin 0 mag 500, SKIP_DC=1 -> peak_bin=3, peak_mag=100. With SKIP_DC=0 -> peak_bin=0, peak_mag=500.
- BIT_REVERSE=1, bin 1 stored at address 32 with value {7,0} -> out_bin=1 has out_mag=7; address_b=32 in pair 0 FETCH.
- out_ready toggled 1-of-3 cycles, plus start pulsed mid-sweep -> identical word sequence to the first test; no duplicates/drops; second start ignored.
- Assert reset during EMIT_B of pair 7 -> all outputs 0 in the same cycle; no done; a later start produces a full 32-word sweep.
